// File: rtl/mem_change_logger_if.sv
// -----------------------------------------------------------------------------
// mem_change_logger_if
// Record stream carrying one change record {idx, data, seq} from the logger to
// its consumer using a valid/ready handshake.
//   rec_valid  head record is presented
//   rec_ready  consumer accepts the head record at the next rising edge
//   rec_idx    watched-word index 0..5
//   rec_data   captured word value
//   rec_seq    record sequence number (0 when the counter is not built)
// Modports: master = logger side, slave = consumer side.
// -----------------------------------------------------------------------------
interface mem_change_logger_if #(
    parameter int W = 16
);
    logic         rec_valid;
    logic         rec_ready;
    logic [2:0]   rec_idx;
    logic [W-1:0] rec_data;
    logic [7:0]   rec_seq;

    modport master (output rec_valid, rec_idx, rec_data, rec_seq, input rec_ready);
    modport slave  (input rec_valid, rec_idx, rec_data, rec_seq, output rec_ready);
endinterface

// File: rtl/mem_change_logger.sv
// -----------------------------------------------------------------------------
// mem_change_logger
// Watches six W-bit memory words and logs every sampled change as a record
// {index, value, sequence} in a first-word-fall-through FIFO that a consumer
// drains over a valid/ready stream.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears all state
//   m0_in..m5_in  watched memory words
//   sample_en  compare and capture the watched words this cycle
//   rec        record stream (master modport of mem_change_logger_if)
//   coalesced  sticky: a change merged into an already-pending one
//   level      FIFO occupancy
//
// Configuration
//   MEM_LOG_SEQ_EN  defined: an 8-bit sequence counter is built and stored per
//                   record. Undefined: no counter, rec_seq is tied to 0.
// -----------------------------------------------------------------------------
module mem_change_logger #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             m0_in,
    input  logic [W-1:0]             m1_in,
    input  logic [W-1:0]             m2_in,
    input  logic [W-1:0]             m3_in,
    input  logic [W-1:0]             m4_in,
    input  logic [W-1:0]             m5_in,
    input  logic                     sample_en,
    mem_change_logger_if.master      rec,
    output logic                     coalesced,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = 6;

    typedef struct packed {
        logic [2:0]   idx;
        logic [W-1:0] data;
`ifdef MEM_LOG_SEQ_EN
        logic [7:0]   seq;
`endif
    } rec_t;

    logic [W-1:0]  m_in [NW];
    logic [W-1:0]  sh   [NW];
    logic [NW-1:0] pend;
    logic [NW-1:0] pend_nxt;
    logic [NW-1:0] changed;
    logic [NW-1:0] push_mask;
    logic [2:0]    rr;
    logic [2:0]    sel;
    logic          found;
    logic          push;
    logic          pop;
    logic          full;
    logic          merge;
    rec_t          mem [DEPTH];
    rec_t          push_rec;
    rec_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
`ifdef MEM_LOG_SEQ_EN
    logic [7:0]    seq;
`endif

    assign m_in[0] = m0_in;
    assign m_in[1] = m1_in;
    assign m_in[2] = m2_in;
    assign m_in[3] = m3_in;
    assign m_in[4] = m4_in;
    assign m_in[5] = m5_in;

    always_comb begin
        for (int i = 0; i < NW; i++) begin
            changed[i] = sample_en && (m_in[i] != sh[i]);
        end
    end

    // Round-robin search starting at rr for the first pending word.
    always_comb begin
        logic [2:0] j;
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        found = 1'b0;
        sel   = '0;
        j     = '0;
        for (int off = 0; off < NW; off++) begin
            j = 3'((int'(rr) + off) % NW);
            if (!found && pend[j]) begin
                found = 1'b1;
                sel   = j;
            end
        end
    end

    // Full test uses occupancy before any same-cycle pop.
    assign full  = (count == (AW+1)'(DEPTH));
    assign push  = found && !full;
    assign pop   = rec.rec_valid && rec.rec_ready;

    assign push_mask = push ? (NW'(1) << sel) : '0;
    // A capture on the word being pushed re-arms its pending bit; that is not a merge.
    assign pend_nxt  = (pend & ~push_mask) | changed;
    assign merge     = |(changed & pend & ~push_mask);

    always_comb begin
        push_rec      = '0;
        push_rec.idx  = sel;
        push_rec.data = sh[sel];
`ifdef MEM_LOG_SEQ_EN
        push_rec.seq  = seq;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) begin
                sh[i] <= '0;
            end
            pend      <= '0;
            rr        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            coalesced <= 1'b0;
`ifdef MEM_LOG_SEQ_EN
            seq       <= '0;
`endif
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (changed[i]) sh[i] <= m_in[i];
            end
            pend <= pend_nxt;
            if (merge) coalesced <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr     <= (sel == 3'd5) ? 3'd0 : sel + 3'd1;
`ifdef MEM_LOG_SEQ_EN
                seq    <= seq + 8'd1;
`endif
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // NOTE: FIFO storage is not reset; count gates validity and the outputs are forced to 0 when empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_rec;
    end

    assign head          = mem[rd_ptr];
    assign rec.rec_valid = (count != '0);
    assign rec.rec_idx   = rec.rec_valid ? head.idx  : '0;
    assign rec.rec_data  = rec.rec_valid ? head.data : '0;
`ifdef MEM_LOG_SEQ_EN
    assign rec.rec_seq   = rec.rec_valid ? head.seq  : '0;
`else
    assign rec.rec_seq   = '0;
`endif
    assign level         = count;

endmodule
